// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared encodings for the MIPS MEM stage (LSU states, access sizes).
// Rev    : 1.0  initial release
// ============================================================================
package mips_pkg;

   localparam logic [1:0] LSU_IDLE = 2'd0;
   localparam logic [1:0] LSU_BUSY = 2'd1;
   localparam logic [1:0] LSU_DONE = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Size code 3 behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic r;
      case (size)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = offset[0];
         default: r = (offset != 2'b00);
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Big-endian lane select and sign/zero extension of a read word.
// Rev    : 1.0  initial release
// ============================================================================
module load_align
   import mips_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (offset)
         2'd0:    w_byte = rdata[31:24];
         2'd1:    w_byte = rdata[23:16];
         2'd2:    w_byte = rdata[15:8];
         default: w_byte = rdata[7:0];
      endcase
      w_half = offset[1] ? rdata[15:0] : rdata[31:16];

      case (size)
         SZ_BYTE: result = {{24{is_signed & w_byte[7]}}, w_byte};
         SZ_HALF: result = {{16{is_signed & w_half[15]}}, w_half};
         default: result = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : MEM-stage load/store engine with a single-outstanding memory port.
// Rev    : 1.0  initial release
// ============================================================================
module load_store_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemUnsigned,
   input  logic [31:0] ALUOut,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignedExc,
   output logic        BusErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [29:0]        r_addr;
   logic               r_we;
   logic [3:0]         r_be;
   logic [31:0]        r_wdata;
   logic [1:0]         r_size;
   logic [1:0]         r_off;
   logic               r_uns;
   logic [31:0]        r_rdata;
   logic               r_buserr;

   logic               w_access;
   logic               w_misaligned;
   logic               w_accept;
   logic               w_done_ok;
   logic               w_timeout;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic [31:0]        w_load;

   assign w_access     = MemRead | MemWrite;
   assign w_misaligned = is_misaligned(MemSize, ALUOut[1:0]);
   assign w_accept     = (r_state == LSU_IDLE) && w_access && !w_misaligned;
   assign w_done_ok    = (r_state == LSU_BUSY) && mem_ready;
   assign w_timeout    = (r_state == LSU_BUSY) && !mem_ready && (r_cnt == c_cnt_last);

   // Stores replicate the datum across lanes; enables pick the addressed bytes.
   always_comb begin
      case (MemSize)
         SZ_BYTE: begin
            w_wdata = {4{WriteData[7:0]}};
            w_be    = 4'b1000 >> ALUOut[1:0];
         end
         SZ_HALF: begin
            w_wdata = {2{WriteData[15:0]}};
            w_be    = ALUOut[1] ? 4'b0011 : 4'b1100;
         end
         default: begin
            w_wdata = WriteData;
            w_be    = 4'b1111;
         end
      endcase
   end

   load_align u_load_align (
      .rdata     (mem_rdata),
      .offset    (r_off),
      .size      (r_size),
      .is_signed (!r_uns),
      .result    (w_load)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LSU_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         LSU_IDLE: if (w_accept) w_next_state = LSU_BUSY;
         LSU_BUSY: if (w_done_ok || w_timeout) w_next_state = LSU_DONE;
         LSU_DONE: w_next_state = LSU_IDLE;
         default:  w_next_state = LSU_IDLE;
      endcase
   end

   always_comb begin
      mem_req       = (r_state == LSU_BUSY);
      Stall         = rst_n && (w_accept || (r_state == LSU_BUSY));
      MisalignedExc = rst_n && (r_state == LSU_IDLE) && w_access && w_misaligned;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_be     <= 4'b0000;
         r_wdata  <= '0;
         r_size   <= SZ_BYTE;
         r_off    <= 2'b00;
         r_uns    <= 1'b0;
         r_rdata  <= '0;
         r_buserr <= 1'b0;
      end else begin
         r_buserr <= w_timeout;
         if (w_accept) begin
            r_cnt   <= '0;
            r_addr  <= ALUOut[31:2];
            r_we    <= MemWrite;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_size  <= MemSize;
            r_off   <= ALUOut[1:0];
            r_uns   <= MemUnsigned;
         end else if (r_state == LSU_BUSY && r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + c_cnt_one;
         end
         // Result register only moves on load completion; stores leave it intact.
         if (w_done_ok && !r_we)      r_rdata <= w_load;
         else if (w_timeout && !r_we) r_rdata <= '0;
      end
   end

   assign ReadData  = r_rdata;
   assign BusErr    = r_buserr;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_be    = r_be;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed plus randomized self-checking bench for load_store_unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite, MemUnsigned;
   logic [1:0]  MemSize;
   logic [31:0] ALUOut, WriteData;
   logic [31:0] ReadData;
   logic        Stall, MisalignedExc, BusErr;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int          passed = 0;
   int          total  = 0;
   logic [31:0] exp_rd;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .MemSize       (MemSize),
      .MemUnsigned   (MemUnsigned),
      .ALUOut        (ALUOut),
      .WriteData     (WriteData),
      .ReadData      (ReadData),
      .Stall         (Stall),
      .MisalignedExc (MisalignedExc),
      .BusErr        (BusErr),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be),
      .mem_ready     (mem_ready),
      .mem_rdata     (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   // Reference model: reason in terms of which memory bytes an access touches.
   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
      logic [3:0] be = 4'b0000;
      int off = int'(addr[1:0]);
      for (int b = off; b < off + nbytes(sz); b++) be[3 - b] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] w = '0;
      int n = nbytes(sz);
      for (int b = 0; b < 4; b++) w = w | (((wd >> (8 * (n - 1 - (b % n)))) & 32'hFF) << (8 * (3 - b)));
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] addr,
                                              input logic uns, input logic [31:0] rd);
      longint v = 0;
      int off = int'(addr[1:0]);
      int n = nbytes(sz);
      for (int b = off; b < off + n; b++) v = (v << 8) | longint'((rd >> (8 * (3 - b))) & 32'hFF);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   // One aligned access with mem_ready in cycle k (k >= 1); returns in the DONE cycle.
   task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                         input int k);
      logic is_store = wr;
      tick();
      MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = uns;
      ALUOut = addr; WriteData = wd; mem_ready = 1'b0;
      #1;
      check("c0_stall", Stall, 1'b1);
      check("c0_req", mem_req, 1'b0);
      check("c0_misal", MisalignedExc, 1'b0);
      for (int j = 1; j <= k; j++) begin
         tick();
         mem_rdata = $urandom;
         check("busy_req", mem_req, 1'b1);
         check("busy_stall", Stall, 1'b1);
         check("busy_we", mem_we, is_store);
         check("busy_addr", mem_addr, addr[31:2]);
         check("busy_be", mem_be, model_be(sz, addr));
         if (is_store) check("busy_wdata", mem_wdata, model_wdata(sz, wd));
         if (j == k) begin
            mem_ready = 1'b1;
            mem_rdata = rdat;
         end
      end
      tick();
      mem_ready = 1'b0;
      if (!is_store) exp_rd = model_load(sz, addr, uns, rdat);
      check("done_stall", Stall, 1'b0);
      check("done_req", mem_req, 1'b0);
      check("done_buserr", BusErr, 1'b0);
      check("done_rdata", ReadData, exp_rd);
   endtask

   initial begin
      rst_n = 1'b0;
      MemRead = 0; MemWrite = 0; MemSize = 0; MemUnsigned = 0;
      ALUOut = 0; WriteData = 0; mem_ready = 0; mem_rdata = 0;
      exp_rd = '0;
      #3;
      check("rst_req", mem_req, 1'b0);
      check("rst_stall", Stall, 1'b0);
      check("rst_be", mem_be, 4'b0000);
      check("rst_addr", mem_addr, 30'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_rdata", ReadData, 32'h0);
      check("rst_buserr", BusErr, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // Directed cases
      access(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2);       // sw
      access(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h123456F0, 1);       // lb
      check("lb_value", ReadData, 32'hFFFFFFF0);
      access(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h123456F0, 1);       // lbu
      check("lbu_value", ReadData, 32'h000000F0);
      access(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 3);       // sh
      access(1'b1, 1'b1, 2'd2, 1'b0, 32'h50, 32'h01020304, 32'hFFFFFFFF, 1); // both -> store

      // Misaligned word load
      tick();
      MemRead = 1; MemWrite = 0; MemSize = 2; ALUOut = 32'h101;
      #1;
      check("mis_pulse", MisalignedExc, 1'b1);
      check("mis_stall", Stall, 1'b0);
      check("mis_req0", mem_req, 1'b0);
      MemRead = 0;
      tick();
      check("mis_req1", mem_req, 1'b0);
      check("mis_clear", MisalignedExc, 1'b0);

      // Timeout on a load
      access(1'b1, 1'b0, 2'd1, 1'b0, 32'h206, 32'h0, 32'h0000C001, 1);       // nonzero ReadData first
      tick();
      MemRead = 1; MemWrite = 0; MemSize = 2; ALUOut = 32'h300;
      #1;
      check("to_stall0", Stall, 1'b1);
      for (int j = 1; j <= 4; j++) begin
         tick();
         check("to_req", mem_req, 1'b1);
         check("to_noerr", BusErr, 1'b0);
      end
      tick();
      exp_rd = '0;
      check("to_buserr", BusErr, 1'b1);
      check("to_rdata", ReadData, exp_rd);
      check("to_stall", Stall, 1'b0);
      check("to_req_off", mem_req, 1'b0);
      MemRead = 0;
      tick();
      check("to_pulse_end", BusErr, 1'b0);
      check("to_idle", mem_req, 1'b0);

      // Reset during BUSY
      tick();
      MemRead = 1; MemSize = 2; ALUOut = 32'h400;
      tick();
      check("rb_req", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      exp_rd = '0;
      check("rb_req_off", mem_req, 1'b0);
      check("rb_stall", Stall, 1'b0);
      check("rb_be", mem_be, 4'b0000);
      MemRead = 0;
      @(negedge clk) rst_n = 1'b1;
      access(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'hCAFEF00D, 1);

      // Randomized aligned traffic against the model
      for (int t = 0; t < 40; t++) begin
         logic [1:0]  sz   = 2'($urandom_range(0, 3));
         logic [31:0] addr = $urandom;
         logic        wr   = 1'($urandom);
         logic        rd   = wr ? 1'($urandom) : 1'b1;
         if (sz == 2'd1) addr[0] = 1'b0;
         else if (sz != 2'd0) addr[1:0] = 2'b00;
         access(rd, wr, sz, 1'($urandom), addr, $urandom, $urandom, $urandom_range(1, 3));
      end

      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store engine for the 32-bit MIPS datapath. It takes the ALU-computed address and the store data from EX/MEM and runs a single-outstanding request/ready transaction with data memory. Store data is formatted to byte lanes. Load data is extracted and sign- or zero-extended into `ReadData`, which feeds the write-back mux. It stalls the pipeline while the memory is busy and flags misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, 255: cycles to wait for `mem_ready` before a bus error.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request, held stable while `Stall`=1.
- `MemWrite` in 1: store request, held stable while `Stall`=1.
- `MemSize` in 2: 0=byte, 1=half, 2=word (3 is treated as word).
- `MemUnsigned` in 1: load zero-extends (lbu/lhu).
- `ALUOut` in 32: effective byte address.
- `WriteData` in 32: store data from rt, right-justified.
- `ReadData` out 32: extended load result, to the write-back mux.
- `Stall` out 1: freeze PC and IF/ID, ID/EX, EX/MEM.
- `MisalignedExc` out 1: one-cycle pulse.
- `BusErr` out 1: one-cycle pulse.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 30: word address, `ALUOut[31:2]`.
- `mem_wdata` out 32: lane-formatted store data.
- `mem_be` out 4: byte enables; bit3 = bits 31:24.
- `mem_ready` in 1: memory completed the request this cycle.
- `mem_rdata` in 32: read word, valid with `mem_ready`.

## Operation
- Big-endian addressing: byte offset 0 maps to bits 31:24.
- Alignment rules:
  - A half access is misaligned if `ALUOut[0]`=1.
  - A word access is misaligned if `ALUOut[1:0]`≠0.
- When `MemRead` and `MemWrite` are both 1, the access is a store.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - Aligned access → BUSY. Register address, `mem_we`, `mem_be`, `mem_wdata`, size and sign.
  - Misaligned access → pulse `MisalignedExc` for 1 cycle. No memory access, stay IDLE.
  - No access → stay IDLE.
- BUSY:
  - `mem_req`=1 and all request outputs are held constant.
  - Wait counter increments each cycle.
  - On `mem_ready`=1: capture the extended load result (loads only), → DONE.
  - When the counter reaches `TIMEOUT`: pulse `BusErr`, set `ReadData`=0, → DONE.
- DONE → IDLE unconditionally. In DONE the captured op is not re-accepted even though `MemRead`/`MemWrite` may still be high.
- Store lane formatting:
  - Byte: data replicated to all lanes; `mem_be` = 1000/0100/0010/0001 for offsets 0..3.
  - Half: data replicated to both halves; `mem_be` = 1100 or 0011.
  - Word: `mem_be` = 1111.
- Load extraction: select the lane by offset and size, then sign-extend unless `MemUnsigned` is 1.
- `ReadData` changes only when a load completes or times out. It is held otherwise, including across stores.

## Timing
- `Stall` is combinational:
  - 1 in IDLE when an aligned access is present.
  - 1 throughout BUSY.
  - 0 in DONE.
  - 0 for a misaligned access.
- Latency: the access is presented in cycle 0 and `mem_req` rises in cycle 1.
  - With `mem_ready` in cycle k: state is DONE in cycle k+1, `ReadData` is valid, `Stall`=0, and the pipeline advances.
  - Minimum total is 3 cycles (k=1).
- The memory may assert `mem_ready` in the first `mem_req` cycle.
- `mem_ready` outside BUSY is ignored.
- Back-to-back accesses: the next access is accepted in the first IDLE cycle after DONE.
- Timeout: if `mem_req` has been high for `TIMEOUT` cycles without `mem_ready`, `BusErr` pulses in the following cycle (DONE).
- Reset, asynchronous and possible mid-transaction:
  - State → IDLE, counter → 0.
  - `mem_req`, `mem_we`, `mem_be` → 0.
  - `mem_addr`, `mem_wdata`, `ReadData` → 0.
  - `MisalignedExc`, `BusErr` → 0; `Stall` → 0.

## Structure
- Shared `mips_pkg` holds:
  - State encoding: `LSU_IDLE`=0, `LSU_BUSY`=1, `LSU_DONE`=2.
  - Size constants: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
- One natural sub-module, `load_align`: a combinational lane select and extend taking `mem_rdata`, offset, size and sign, producing 32 bits. It can be reused by a future I-cache bypass.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide and saturates.

## Test plan
- **sw**: `ALUOut`=0x100, `WriteData`=0xDEADBEEF, `mem_ready` after 2 cycles → `mem_addr`=0x40, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `Stall` high for 3 cycles, `ReadData` unchanged.
- **lb / lbu**: `ALUOut`=0x103, `mem_rdata`=0x123456F0 → lb gives `ReadData`=0xFFFFFFF0; lbu gives 0x000000F0. `mem_be`=0001.
- **sh**: `ALUOut`=0x202, `WriteData`=0x0000ABCD → `mem_wdata`=0xABCDABCD, `mem_be`=0011.
- **Misaligned lw**: `ALUOut`=0x101 → `MisalignedExc`=1 for one cycle, `mem_req` never rises, `Stall`=0.
- **Timeout**: `TIMEOUT`=4, `mem_ready` held 0 → `BusErr` pulses once in the cycle after 4 `mem_req` cycles, `ReadData`=0, `Stall` drops, FSM back to IDLE.
- **Reset mid-BUSY**: `rst_n` low during BUSY → `mem_req`=0 and `Stall`=0 immediately. After release, a new lw completes normally.
